// File: rtl/ramp_checker.sv
// Ramp sequence checker: locks onto an incrementing sample stream, flywheels
// through isolated glitches and reports mismatches seen while locked.
module ramp_checker #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned COUNT_FROM = 0,
    parameter int unsigned COUNT_TO   = 255,
    parameter int unsigned STEP       = 1,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned MISS_LIMIT = 3,
    parameter int unsigned ERR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  clr,
    output logic                  locked,
    output logic                  err_pulse,
    output logic [ERR_WIDTH-1:0]  err_count,
    output logic [DATA_WIDTH-1:0] last_bad
);

    localparam int unsigned MATCH_W = $clog2(LOCK_COUNT + 1);
    localparam int unsigned MISS_W  = $clog2(MISS_LIMIT + 1);

    typedef enum logic [1:0] {
        S_SEARCH = 2'd0,
        S_VERIFY = 2'd1,
        S_LOCKED = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic [MATCH_W-1:0]    match_q, match_d;
    logic [MISS_W-1:0]     miss_q, miss_d;
    logic                  locked_q, locked_d;
    logic                  pulse_q, pulse_d;
    logic [ERR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] bad_q, bad_d;

    logic [DATA_WIDTH-1:0] exp_c;
    logic                  hit_c;
    logic [MATCH_W-1:0]    match_inc_c;
    logic [MISS_W-1:0]     miss_inc_c;
    logic [ERR_WIDTH-1:0]  cnt_base_c;

    // Next expected ramp value, wrapping back to COUNT_FROM past COUNT_TO
    assign exp_c       = (prev_q >= DATA_WIDTH'(COUNT_TO)) ? DATA_WIDTH'(COUNT_FROM)
                                                           : prev_q + DATA_WIDTH'(STEP);
    assign hit_c       = (din == exp_c);
    assign match_inc_c = match_q + MATCH_W'(1);
    assign miss_inc_c  = miss_q + MISS_W'(1);
    assign cnt_base_c  = clr ? '0 : cnt_q;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        match_d = match_q;
        miss_d  = miss_q;
        pulse_d = 1'b0;
        cnt_d   = cnt_base_c;
        bad_d   = clr ? '0 : bad_q;

        if (en) begin
            unique case (state_q)
                S_SEARCH: begin
                    prev_d  = din;
                    match_d = '0;
                    state_d = S_VERIFY;
                end
                S_VERIFY: begin
                    prev_d = din;
                    if (hit_c) begin
                        match_d = match_inc_c;
                        if (match_inc_c == MATCH_W'(LOCK_COUNT)) begin
                            state_d = S_LOCKED;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                S_LOCKED: begin
                    if (hit_c) begin
                        prev_d = din;
                        miss_d = '0;
                    end else begin
                        // Flywheel: keep counting along the ideal ramp
                        prev_d  = exp_c;
                        miss_d  = miss_inc_c;
                        pulse_d = 1'b1;
                        cnt_d   = (&cnt_base_c) ? cnt_base_c : cnt_base_c + ERR_WIDTH'(1);
                        bad_d   = din;
                        if (miss_inc_c == MISS_W'(MISS_LIMIT)) begin
                            state_d = S_SEARCH;
                        end
                    end
                end
                default: begin
                    state_d = S_SEARCH;
                end
            endcase
        end

        locked_d = (state_d == S_LOCKED);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_SEARCH;
            prev_q   <= '0;
            match_q  <= '0;
            miss_q   <= '0;
            locked_q <= 1'b0;
            pulse_q  <= 1'b0;
            cnt_q    <= '0;
            bad_q    <= '0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            match_q  <= match_d;
            miss_q   <= miss_d;
            locked_q <= locked_d;
            pulse_q  <= pulse_d;
            cnt_q    <= cnt_d;
            bad_q    <= bad_d;
        end
    end

    assign locked    = locked_q;
    assign err_pulse = pulse_q;
    assign err_count = cnt_q;
    assign last_bad  = bad_q;

endmodule

// File: doc/ramp_checker.md
# ramp_checker

Downstream consumer of the parameterized counter in the ADC test design. Samples an incoming ramp (counter output or ADC test-pattern data), locks onto the increment sequence and reports lock status and sequence errors. It flywheels through isolated glitches and drops lock after repeated consecutive misses. Results feed the test register block for software readout.

## Interface
- DATA_WIDTH, 8: width of sampled data.
- COUNT_FROM, 0: value the ramp restarts at after wrap.
- COUNT_TO, 255: highest ramp value; the sample after it must be COUNT_FROM.
- STEP, 1: increment per valid sample; must be positive and nonzero.
- LOCK_COUNT, 4: consecutive matches needed to declare lock (≥1).
- MISS_LIMIT, 3: consecutive mismatches while locked that drop lock (≥1).
- ERR_WIDTH, 16: width of error counter.

- clk  in  1  sole clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- en  in  1  din valid this cycle.
- din  in  DATA_WIDTH  ramp sample.
- clr  in  1  synchronous clear of err_count and last_bad.
- locked  out  1  checker is in LOCKED.
- err_pulse  out  1  one-cycle flag per mismatch detected while LOCKED.
- err_count  out  ERR_WIDTH  saturating count of mismatches while LOCKED.
- last_bad  out  DATA_WIDTH  din value of the most recent counted mismatch.

## Operation
- Expected value: exp = (prev ≥ COUNT_TO) ? COUNT_FROM : prev + STEP, computed modulo 2^DATA_WIDTH. prev is an internal DATA_WIDTH register.
- A sample is considered only on cycles with en=1. With en=0, no state, counter or prev changes, and err_pulse=0.
- States: SEARCH, VERIFY, LOCKED.
- SEARCH:
  - Valid sample: prev←din, match_cnt←0, go to VERIFY.
- VERIFY:
  - Valid sample with din==exp: prev←din, match_cnt+1. When match_cnt+1 == LOCK_COUNT, go to LOCKED and set miss_cnt←0.
  - Valid sample with din≠exp: prev←din (reseed), match_cnt←0, stay in VERIFY.
  - No errors are counted outside LOCKED.
- LOCKED:
  - Valid sample with din==exp: prev←din, miss_cnt←0.
  - Valid sample with din≠exp: prev←exp (flywheel), miss_cnt+1, err_pulse=1, err_count+1 (saturates at all-ones), last_bad←din. When miss_cnt+1 == MISS_LIMIT, go to SEARCH.
- clr:
  - Sets err_count←0 and last_bad←0. State, prev and the match/miss counters are unaffected.
  - clr and a counted mismatch in the same cycle: err_count←1, last_bad←din, err_pulse=1.
- Saturation: once err_count reaches 2^ERR_WIDTH−1 it holds. err_pulse and last_bad still update.
- Reset (asserted at any time, including mid-lock): immediately forces state SEARCH, prev=0, match_cnt=0, miss_cnt=0, locked=0, err_pulse=0, err_count=0, last_bad=0.

## Timing
- All outputs are registered. Effects of a sample accepted at edge N are visible after edge N.
- locked rises on the edge that accepts the LOCK_COUNT-th consecutive match, which is the (LOCK_COUNT+1)-th valid sample after SEARCH.
- locked falls on the edge that accepts the MISS_LIMIT-th consecutive miss. That miss is still counted and pulses err_pulse.
- err_pulse is high for exactly one cycle per counted mismatch. Back-to-back misses give back-to-back pulses.
- Reset release: the first rising edge with rst=1 may accept a sample. There is no extra latency.
- Throughput: one sample per clock, with no back-pressure.

## Test plan
- Lock-in: reset, then drive en=1 with din=10,11,12,13,14 → locked=0 through the 4th edge and =1 after the edge accepting 14. err_count=0.
- Wrap: locked, drive din=254,255,0,1 with COUNT_TO=255 → no err_pulse, locked stays 1. Repeat with COUNT_FROM=16, COUNT_TO=31: din 30,31,16 → no error.
- Single glitch: locked at 40, drive 41,99,43,44 → one err_pulse after 99, err_count=1, last_bad=99, locked stays 1 (flywheel accepts 43).
- Loss of lock: locked at 40, drive 99,99,99 → err_count=3, locked=0 after the third miss. Then 50..54 → relock after the edge accepting 54.
- en gaps, clr and saturation: insert en=0 cycles with garbage din mid-ramp → no errors. Pulse clr together with a miss → err_count=1. With ERR_WIDTH=2, five misses interleaved with matches → err_count holds at 3 while err_pulse still fires.
- Async reset mid-lock: assert rst=0 between edges while locked with err_count=5 → all outputs 0 immediately without a clock edge. After release, relock requires 5 valid samples.
